// File: rtl/periph_axi_demux_if.sv
// periph_axi_demux_if
//   Single-beat ready/valid message bundle (AW, W, B, AR, R) carrying
//   NP parallel lanes. On the upstream side NP=1. On the downstream side
//   NP=NUM_PORTS: AW/W/AR payloads are broadcast, so only valid/ready are
//   per-lane. B/R payloads are packed with lane i at slice i.
//   Message layouts:
//     aw/ar : {id, addr}
//     w     : {strb, data}
//     b     : {id, resp}
//     r     : {id, resp, data}
//   Modports:
//     master : issues requests (AW/W/AR) and accepts responses (B/R).
//     slave  : accepts requests and issues responses.
interface periph_axi_demux_if #(
  parameter int NP     = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  localparam int AX_W = ID_W + ADDR_W;
  localparam int W_W  = DATA_W / 8 + DATA_W;
  localparam int B_W  = ID_W + 2;
  localparam int R_W  = ID_W + 2 + DATA_W;

  logic [NP-1:0]      aw_valid;
  logic [NP-1:0]      aw_ready;
  logic [AX_W-1:0]    aw_msg;
  logic [NP-1:0]      w_valid;
  logic [NP-1:0]      w_ready;
  logic [W_W-1:0]     w_msg;
  logic [NP-1:0]      b_valid;
  logic [NP-1:0]      b_ready;
  logic [NP*B_W-1:0]  b_msg;
  logic [NP-1:0]      ar_valid;
  logic [NP-1:0]      ar_ready;
  logic [AX_W-1:0]    ar_msg;
  logic [NP-1:0]      r_valid;
  logic [NP-1:0]      r_ready;
  logic [NP*R_W-1:0]  r_msg;

  modport master (
    output aw_valid, aw_msg, w_valid, w_msg, b_ready, ar_valid, ar_msg, r_ready,
    input  aw_ready, w_ready, b_valid, b_msg, ar_ready, r_valid, r_msg
  );

  modport slave (
    input  aw_valid, aw_msg, w_valid, w_msg, b_ready, ar_valid, ar_msg, r_ready,
    output aw_ready, w_ready, b_valid, b_msg, ar_ready, r_valid, r_msg
  );
endinterface

// File: rtl/periph_axi_demux.sv
// periph_axi_demux
//   1-to-NUM_PORTS peripheral router. It decodes the request address
//   against per-port base/mask windows, where the lowest matching port
//   wins. It then forwards single-beat writes and reads through two
//   independent engines. An address that matches no port is answered
//   locally with DECERR (2'b11), and the miss is counted in a saturating
//   counter.
//   Ports:
//     clk, reset_bar : clock and asynchronous active-low reset
//     s_bus          : upstream bundle (NP=1), this block is the slave
//     m_bus          : downstream bundle (NP=NUM_PORTS), this block is the master
//     wr_decerr_cnt  : saturating count of write address misses
//     rd_decerr_cnt  : saturating count of read address misses
module periph_axi_demux #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter logic [NUM_PORTS*ADDR_W-1:0] BASE_ADDR = {NUM_PORTS{32'h0}},
  parameter logic [NUM_PORTS*ADDR_W-1:0] ADDR_MASK = {NUM_PORTS{32'hFFFF_0000}},
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_bar,
  periph_axi_demux_if.slave    s_bus,
  periph_axi_demux_if.master   m_bus,
  output logic [CNT_W-1:0]     wr_decerr_cnt,
  output logic [CNT_W-1:0]     rd_decerr_cnt
);
  localparam int AX_W   = ID_W + ADDR_W;
  localparam int W_W    = DATA_W / 8 + DATA_W;
  localparam int B_W    = ID_W + 2;
  localparam int R_W    = ID_W + 2 + DATA_W;
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [2:0] WR_IDLE = 3'd0;
  localparam logic [2:0] WR_DATA = 3'd1;
  localparam logic [2:0] WR_FWD  = 3'd2;
  localparam logic [2:0] WR_RESP = 3'd3;
  localparam logic [2:0] WR_BOUT = 3'd4;

  localparam logic [1:0] RD_IDLE = 2'd0;
  localparam logic [1:0] RD_FWD  = 2'd1;
  localparam logic [1:0] RD_RESP = 2'd2;
  localparam logic [1:0] RD_ROUT = 2'd3;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  // The result is {miss, port}. The loop scans from the highest index down,
  // so the lowest matching port is the one left in the result.
  function automatic logic [PORT_W:0] decode(input logic [ADDR_W-1:0] addr);
    logic [PORT_W:0] res;
    // NOTE: give every variable a value before any conditional assignment,
    // so that no path leaves it unassigned. Otherwise a latch is inferred.
    res = {1'b1, {PORT_W{1'b0}}};
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if ((addr & ADDR_MASK[i*ADDR_W +: ADDR_W]) ==
          (BASE_ADDR[i*ADDR_W +: ADDR_W] & ADDR_MASK[i*ADDR_W +: ADDR_W]))
        res = {1'b0, PORT_W'(i)};
    end
    return res;
  endfunction

  // Set on the first edge after reset release. It keeps both engines from
  // accepting a request while reset is still being released.
  logic rst_done;

  always_ff @(posedge clk or negedge reset_bar) begin
    // NOTE: sequential state always uses non-blocking assignments. Every flop
    // then samples pre-edge values, whatever order the blocks are evaluated in.
    if (!reset_bar) rst_done <= 1'b0;
    else            rst_done <= 1'b1;
  end

  // ---------------- write engine ----------------
  logic [2:0]            wr_state;
  logic [AX_W-1:0]       aw_msg_q;
  logic [W_W-1:0]        w_msg_q;
  logic [B_W-1:0]        b_msg_q;
  logic [PORT_W-1:0]     wr_port;
  logic                  wr_miss;
  logic                  aw_done, w_done;
  logic [NUM_PORTS-1:0]  wr_sel;
  logic [PORT_W-1:0]     wr_dec_port;
  logic                  wr_dec_miss;
  logic                  aw_hs, w_hs, m_aw_hs, m_w_hs, m_b_hs;

  assign {wr_dec_miss, wr_dec_port} = decode(s_bus.aw_msg[ADDR_W-1:0]);
  assign wr_sel = NUM_PORTS'(1) << wr_port;

  assign s_bus.aw_ready = rst_done && (wr_state == WR_IDLE);
  assign s_bus.w_ready  = (wr_state == WR_DATA);
  assign s_bus.b_valid  = (wr_state == WR_BOUT);
  assign s_bus.b_msg    = b_msg_q;

  // AW and W are offered together. Each one is withdrawn as soon as its own
  // handshake completes, so a slow W does not hold AW.
  assign m_bus.aw_valid = (wr_state == WR_FWD && !aw_done) ? wr_sel : '0;
  assign m_bus.w_valid  = (wr_state == WR_FWD && !w_done)  ? wr_sel : '0;
  assign m_bus.b_ready  = (wr_state == WR_RESP) ? wr_sel : '0;
  assign m_bus.aw_msg   = aw_msg_q;
  assign m_bus.w_msg    = w_msg_q;

  assign aw_hs   = s_bus.aw_valid[0] & s_bus.aw_ready[0];
  assign w_hs    = s_bus.w_valid[0] & s_bus.w_ready[0];
  assign m_aw_hs = |(m_bus.aw_valid & m_bus.aw_ready);
  assign m_w_hs  = |(m_bus.w_valid & m_bus.w_ready);
  assign m_b_hs  = |(m_bus.b_valid & m_bus.b_ready);

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      // NOTE: the payload registers are reset as well as the control state.
      // Message outputs are therefore defined (zero) out of reset, not X.
      wr_state      <= WR_IDLE;
      aw_msg_q      <= '0;
      w_msg_q       <= '0;
      b_msg_q       <= '0;
      wr_port       <= '0;
      wr_miss       <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      wr_decerr_cnt <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: if (aw_hs) begin
          aw_msg_q <= s_bus.aw_msg;
          wr_port  <= wr_dec_port;
          wr_miss  <= wr_dec_miss;
          wr_state <= WR_DATA;
        end
        WR_DATA: if (w_hs) begin
          w_msg_q <= s_bus.w_msg;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (wr_miss) begin
            b_msg_q  <= {aw_msg_q[AX_W-1:ADDR_W], RESP_DECERR};
            if (wr_decerr_cnt != '1) wr_decerr_cnt <= wr_decerr_cnt + 1'b1;
            wr_state <= WR_BOUT;
          end else begin
            wr_state <= WR_FWD;
          end
        end
        WR_FWD: begin
          if (m_aw_hs) aw_done <= 1'b1;
          if (m_w_hs)  w_done  <= 1'b1;
          if ((aw_done || m_aw_hs) && (w_done || m_w_hs)) wr_state <= WR_RESP;
        end
        WR_RESP: if (m_b_hs) begin
          b_msg_q  <= m_bus.b_msg[wr_port*B_W +: B_W];
          wr_state <= WR_BOUT;
        end
        WR_BOUT: if (s_bus.b_ready[0]) wr_state <= WR_IDLE;
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // ---------------- read engine ----------------
  logic [1:0]            rd_state;
  logic [AX_W-1:0]       ar_msg_q;
  logic [R_W-1:0]        r_msg_q;
  logic [PORT_W-1:0]     rd_port;
  logic [NUM_PORTS-1:0]  rd_sel;
  logic [PORT_W-1:0]     rd_dec_port;
  logic                  rd_dec_miss;
  logic                  ar_hs, m_ar_hs, m_r_hs;

  assign {rd_dec_miss, rd_dec_port} = decode(s_bus.ar_msg[ADDR_W-1:0]);
  assign rd_sel = NUM_PORTS'(1) << rd_port;

  assign s_bus.ar_ready = rst_done && (rd_state == RD_IDLE);
  assign s_bus.r_valid  = (rd_state == RD_ROUT);
  assign s_bus.r_msg    = r_msg_q;

  assign m_bus.ar_valid = (rd_state == RD_FWD)  ? rd_sel : '0;
  assign m_bus.r_ready  = (rd_state == RD_RESP) ? rd_sel : '0;
  assign m_bus.ar_msg   = ar_msg_q;

  assign ar_hs   = s_bus.ar_valid[0] & s_bus.ar_ready[0];
  assign m_ar_hs = |(m_bus.ar_valid & m_bus.ar_ready);
  assign m_r_hs  = |(m_bus.r_valid & m_bus.r_ready);

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      rd_state      <= RD_IDLE;
      ar_msg_q      <= '0;
      r_msg_q       <= '0;
      rd_port       <= '0;
      rd_decerr_cnt <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: if (ar_hs) begin
          ar_msg_q <= s_bus.ar_msg;
          rd_port  <= rd_dec_port;
          if (rd_dec_miss) begin
            r_msg_q  <= {s_bus.ar_msg[AX_W-1:ADDR_W], RESP_DECERR, {DATA_W{1'b0}}};
            if (rd_decerr_cnt != '1) rd_decerr_cnt <= rd_decerr_cnt + 1'b1;
            rd_state <= RD_ROUT;
          end else begin
            rd_state <= RD_FWD;
          end
        end
        RD_FWD: if (m_ar_hs) rd_state <= RD_RESP;
        RD_RESP: if (m_r_hs) begin
          r_msg_q  <= m_bus.r_msg[rd_port*R_W +: R_W];
          rd_state <= RD_ROUT;
        end
        RD_ROUT: if (s_bus.r_ready[0]) rd_state <= RD_IDLE;
        default: rd_state <= RD_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_periph_axi_demux.sv
// Directed bench for periph_axi_demux with two ports: port 0 is at
// 0x0000_xxxx and port 1 is at 0x0001_xxxx. CNT_W is 2, so the error
// counters saturate at 3. The bench plays the upstream master and both
// downstream slaves. Inputs change 1 time unit after a rising edge, and
// outputs are sampled at that same point.
module tb_periph_axi_demux;
  localparam int NUM_PORTS = 2;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int ID_W      = 4;
  localparam int CNT_W     = 2;

  logic clk;
  logic reset_bar;
  logic [CNT_W-1:0] wr_decerr_cnt, rd_decerr_cnt;

  int checks = 0;
  int errors = 0;

  periph_axi_demux_if #(.NP(1), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) s_bus ();
  periph_axi_demux_if #(.NP(NUM_PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) m_bus ();

  periph_axi_demux #(
    .NUM_PORTS(NUM_PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
    .BASE_ADDR({32'h0001_0000, 32'h0000_0000}),
    .ADDR_MASK({32'hFFFF_0000, 32'hFFFF_0000}),
    .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .reset_bar     (reset_bar),
    .s_bus         (s_bus),
    .m_bus         (m_bus),
    .wr_decerr_cnt (wr_decerr_cnt),
    .rd_decerr_cnt (rd_decerr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // all stimulus idle, reset asserted
    reset_bar      = 1'b0;
    s_bus.aw_valid = 1'b0; s_bus.aw_msg = '0;
    s_bus.w_valid  = 1'b0; s_bus.w_msg  = '0;
    s_bus.b_ready  = 1'b0;
    s_bus.ar_valid = 1'b0; s_bus.ar_msg = '0;
    s_bus.r_ready  = 1'b0;
    m_bus.aw_ready = 2'b11;
    m_bus.w_ready  = 2'b11;
    m_bus.b_valid  = 2'b11;
    m_bus.b_msg    = {4'd3, 2'b00, 4'd9, 2'b01};
    m_bus.ar_ready = 2'b11;
    m_bus.r_valid  = 2'b11;
    m_bus.r_msg    = {4'd7, 2'b00, 32'hCAFE_F00D, 4'd0, 2'b01, 32'h1111_1111};

    #23;
    check("rst_s_aw_ready", s_bus.aw_ready, 1'b0);
    check("rst_s_ar_ready", s_bus.ar_ready, 1'b0);
    check("rst_valids", {s_bus.b_valid, s_bus.r_valid, m_bus.aw_valid, m_bus.w_valid, m_bus.ar_valid}, '0);
    check("rst_msgs", {s_bus.b_msg, m_bus.aw_msg}, '0);
    check("rst_cnts", {wr_decerr_cnt, rd_decerr_cnt}, '0);
    tick();
    reset_bar = 1'b1;
    #1;
    check("rel_aw_ready_late", s_bus.aw_ready, 1'b0);
    tick();
    check("rel_aw_ready", s_bus.aw_ready, 1'b1);
    check("rel_ar_ready", s_bus.ar_ready, 1'b1);

    // ---- write hit to port 1 ----
    s_bus.aw_valid = 1'b1; s_bus.aw_msg = {4'd3, 32'h0001_0004};
    check("wh_c0_aw_ready", s_bus.aw_ready, 1'b1);
    tick();
    s_bus.aw_valid = 1'b0;
    s_bus.w_valid = 1'b1; s_bus.w_msg = {4'hF, 32'hDEAD_BEEF};
    check("wh_c1_w_ready", s_bus.w_ready, 1'b1);
    check("wh_c1_no_fwd", m_bus.aw_valid, 2'b00);
    tick();
    s_bus.w_valid = 1'b0;
    check("wh_c2_m_aw_valid", m_bus.aw_valid, 2'b10);
    check("wh_c2_m_w_valid", m_bus.w_valid, 2'b10);
    check("wh_c2_m_aw_msg", m_bus.aw_msg, {4'd3, 32'h0001_0004});
    check("wh_c2_m_w_msg", m_bus.w_msg, {4'hF, 32'hDEAD_BEEF});
    tick();
    check("wh_c3_m_b_ready", m_bus.b_ready, 2'b10);
    check("wh_c3_no_b", s_bus.b_valid, 1'b0);
    tick();
    check("wh_c4_s_b_valid", s_bus.b_valid, 1'b1);
    check("wh_c4_s_b_msg", s_bus.b_msg, {4'd3, 2'b00});
    s_bus.b_ready = 1'b1;
    tick();
    s_bus.b_ready = 1'b0;
    check("wh_c5_b_done", s_bus.b_valid, 1'b0);
    check("wh_c5_aw_ready", s_bus.aw_ready, 1'b1);

    // ---- read miss ----
    s_bus.ar_valid = 1'b1; s_bus.ar_msg = {4'd5, 32'h8000_0000};
    check("rm_c0_ar_ready", s_bus.ar_ready, 1'b1);
    tick();
    s_bus.ar_valid = 1'b0;
    check("rm_c1_no_m_ar", m_bus.ar_valid, 2'b00);
    check("rm_c1_r_valid", s_bus.r_valid, 1'b1);
    check("rm_c1_r_msg", s_bus.r_msg, {4'd5, 2'b11, 32'h0});
    check("rm_c1_cnt", rd_decerr_cnt, 2'd1);
    s_bus.r_ready = 1'b1;
    tick();
    s_bus.r_ready = 1'b0;
    check("rm_done", s_bus.r_valid, 1'b0);

    // ---- write to port 0 with W stalled for 5 cycles ----
    m_bus.w_ready = 2'b00;
    m_bus.b_msg   = {4'd3, 2'b00, 4'd2, 2'b10};
    s_bus.aw_valid = 1'b1; s_bus.aw_msg = {4'd2, 32'h0000_0010};
    tick();
    s_bus.aw_valid = 1'b0;
    s_bus.w_valid = 1'b1; s_bus.w_msg = {4'h3, 32'h1234_5678};
    tick();
    s_bus.w_valid = 1'b0;
    check("ws_f0_aw_valid", m_bus.aw_valid, 2'b01);
    check("ws_f0_w_valid", m_bus.w_valid, 2'b01);
    for (int i = 1; i < 5; i++) begin
      tick();
      check($sformatf("ws_f%0d_aw_dropped", i), m_bus.aw_valid, 2'b00);
      check($sformatf("ws_f%0d_w_valid", i), m_bus.w_valid, 2'b01);
      check($sformatf("ws_f%0d_w_msg", i), m_bus.w_msg, {4'h3, 32'h1234_5678});
      check($sformatf("ws_f%0d_no_b_ready", i), m_bus.b_ready, 2'b00);
    end
    m_bus.w_ready = 2'b01;
    tick();
    m_bus.w_ready = 2'b11;
    check("ws_w_dropped", m_bus.w_valid, 2'b00);
    check("ws_b_ready", m_bus.b_ready, 2'b01);
    tick();
    check("ws_s_b_valid", s_bus.b_valid, 1'b1);
    check("ws_s_b_msg", s_bus.b_msg, {4'd2, 2'b10});
    s_bus.b_ready = 1'b1;
    tick();
    s_bus.b_ready = 1'b0;

    // ---- concurrent write to port 0 and read from port 1, stalled responses ----
    m_bus.b_msg = {4'd3, 2'b00, 4'd1, 2'b00};
    s_bus.aw_valid = 1'b1; s_bus.aw_msg = {4'd1, 32'h0000_0020};
    s_bus.ar_valid = 1'b1; s_bus.ar_msg = {4'd7, 32'h0001_0008};
    tick();
    s_bus.aw_valid = 1'b0; s_bus.ar_valid = 1'b0;
    s_bus.w_valid = 1'b1; s_bus.w_msg = {4'hF, 32'hA5A5_5A5A};
    check("cc_m_ar_valid", m_bus.ar_valid, 2'b10);
    check("cc_m_ar_msg", m_bus.ar_msg, {4'd7, 32'h0001_0008});
    tick();
    s_bus.w_valid = 1'b0;
    check("cc_m_r_ready", m_bus.r_ready, 2'b10);
    check("cc_m_aw_valid", m_bus.aw_valid, 2'b01);
    tick();
    check("cc_r_valid", s_bus.r_valid, 1'b1);
    check("cc_r_msg", s_bus.r_msg, {4'd7, 2'b00, 32'hCAFE_F00D});
    tick();
    check("cc_b_valid", s_bus.b_valid, 1'b1);
    check("cc_b_msg", s_bus.b_msg, {4'd1, 2'b00});
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("cc_stall%0d_valids", i), {s_bus.b_valid, s_bus.r_valid}, 2'b11);
      check($sformatf("cc_stall%0d_b_msg", i), s_bus.b_msg, {4'd1, 2'b00});
      check($sformatf("cc_stall%0d_r_msg", i), s_bus.r_msg, {4'd7, 2'b00, 32'hCAFE_F00D});
    end
    s_bus.b_ready = 1'b1; s_bus.r_ready = 1'b1;
    tick();
    s_bus.b_ready = 1'b0; s_bus.r_ready = 1'b0;
    check("cc_done", {s_bus.b_valid, s_bus.r_valid}, 2'b00);

    // ---- five write misses, counter saturates at 3 ----
    for (int k = 0; k < 5; k++) begin
      s_bus.aw_valid = 1'b1; s_bus.aw_msg = {4'(k + 8), 32'h8000_0000};
      tick();
      s_bus.aw_valid = 1'b0;
      s_bus.w_valid = 1'b1; s_bus.w_msg = {4'hF, 32'h0};
      tick();
      s_bus.w_valid = 1'b0;
      check($sformatf("wm%0d_no_fwd", k), m_bus.aw_valid | m_bus.w_valid, 2'b00);
      check($sformatf("wm%0d_b_msg", k), {s_bus.b_valid, s_bus.b_msg}, {1'b1, 4'(k + 8), 2'b11});
      check($sformatf("wm%0d_cnt", k), wr_decerr_cnt, (k < 3) ? 2'(k + 1) : 2'd3);
      s_bus.b_ready = 1'b1;
      tick();
      s_bus.b_ready = 1'b0;
    end

    // ---- reset while waiting for B on port 1 ----
    m_bus.b_valid = 2'b00;
    s_bus.aw_valid = 1'b1; s_bus.aw_msg = {4'd4, 32'h0001_0000};
    tick();
    s_bus.aw_valid = 1'b0;
    s_bus.w_valid = 1'b1; s_bus.w_msg = {4'h1, 32'h0000_00AA};
    tick();
    s_bus.w_valid = 1'b0;
    tick();
    check("rr_in_resp", m_bus.b_ready, 2'b10);
    reset_bar = 1'b0;
    #1;
    check("rr_b_ready_cleared", m_bus.b_ready, 2'b00);
    check("rr_valids", {s_bus.b_valid, s_bus.r_valid, m_bus.aw_valid, m_bus.w_valid, m_bus.ar_valid}, '0);
    check("rr_cnts", {wr_decerr_cnt, rd_decerr_cnt}, '0);
    tick();
    tick();
    reset_bar = 1'b1;
    #1;
    check("rr_aw_ready_late", s_bus.aw_ready, 1'b0);
    check("rr_no_b", s_bus.b_valid, 1'b0);
    tick();
    check("rr_aw_ready", s_bus.aw_ready, 1'b1);
    m_bus.b_valid = 2'b11;
    m_bus.b_msg   = {4'd6, 2'b00, 4'd9, 2'b01};
    s_bus.aw_valid = 1'b1; s_bus.aw_msg = {4'd6, 32'h0001_0040};
    tick();
    s_bus.aw_valid = 1'b0;
    s_bus.w_valid = 1'b1; s_bus.w_msg = {4'hF, 32'h0BAD_F00D};
    tick();
    s_bus.w_valid = 1'b0;
    check("rr_new_fwd", {m_bus.aw_valid, m_bus.w_valid}, 4'b1010);
    tick();
    tick();
    check("rr_new_b", {s_bus.b_valid, s_bus.b_msg}, {1'b1, 4'd6, 2'b00});
    s_bus.b_ready = 1'b1;
    tick();
    s_bus.b_ready = 1'b0;
    check("rr_new_done", s_bus.b_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/periph_axi_demux.md
Name: periph_axi_demux

Overview:
- Parametrised 1-to-NUM_PORTS peripheral router for the ready/valid message interface between the rocket_subsystem peripheral master and the HLS/SystemC accelerator subsystems.
- Replaces the fixed point-to-point link with address decoding and an independent write engine and read engine.
- An address miss returns a DECERR response locally.
- Provides saturating decode-error counters.

Parameters:
- NUM_PORTS, 2: number of downstream peripheral ports (1..8).
- ADDR_W, 32: address width.
- DATA_W, 32: data width; multiple of 8.
- ID_W, 4: transaction ID width.
- BASE_ADDR, {NUM_PORTS{32'h0}}: packed NUM_PORTS*ADDR_W vector; port i base address at slice i.
- ADDR_MASK, {NUM_PORTS{32'hFFFF_0000}}: packed NUM_PORTS*ADDR_W vector. Port i hits when (addr & mask_i) == (base_i & mask_i).
- CNT_W, 16: error counter width.

Ports:
- clk in 1: clock.
- reset_bar in 1: asynchronous active-low reset.
- s_aw_valid in 1, s_aw_ready out 1, s_aw_msg in ID_W+ADDR_W: upstream AW, layout {id, addr}.
- s_w_valid in 1, s_w_ready out 1, s_w_msg in DATA_W/8+DATA_W: upstream W, layout {strb, data}.
- s_b_valid out 1, s_b_ready in 1, s_b_msg out ID_W+2: upstream B, layout {id, resp}.
- s_ar_valid in 1, s_ar_ready out 1, s_ar_msg in ID_W+ADDR_W: upstream AR.
- s_r_valid out 1, s_r_ready in 1, s_r_msg out ID_W+2+DATA_W: upstream R, layout {id, resp, data}.
- m_aw_valid out NUM_PORTS, m_aw_ready in NUM_PORTS, m_aw_msg out ID_W+ADDR_W: AW payload broadcast to all ports, one-hot valid.
- m_w_valid out NUM_PORTS, m_w_ready in NUM_PORTS, m_w_msg out DATA_W/8+DATA_W.
- m_b_valid in NUM_PORTS, m_b_ready out NUM_PORTS, m_b_msg in NUM_PORTS*(ID_W+2): packed, port i at slice i.
- m_ar_valid out NUM_PORTS, m_ar_ready in NUM_PORTS, m_ar_msg out ID_W+ADDR_W.
- m_r_valid in NUM_PORTS, m_r_ready out NUM_PORTS, m_r_msg in NUM_PORTS*(ID_W+2+DATA_W).
- wr_decerr_cnt out CNT_W, rd_decerr_cnt out CNT_W: saturating miss counters.

Behaviour:
- Reset (reset_bar=0, asynchronous): both FSMs return to IDLE; all valid/ready outputs 0; all msg registers 0; counters 0.
- rst_done flop resets to 0 and sets to 1 on the first clk edge after reset release. All IDLE readies are gated by rst_done.
- Reset mid-transaction drops the transaction silently; no response is generated.
- Single beat only; one outstanding write and one outstanding read. The read and write engines are fully independent and may run concurrently to the same or different ports.
- Decode: combinational on the captured address. The lowest matching index wins. No match means miss.
- Write FSM states:
  - WR_IDLE: s_aw_ready=1. On AW handshake, register the msg and the decoded port/miss, then go to WR_DATA.
  - WR_DATA: s_w_ready=1. On W handshake, register the msg. On miss go to WR_BOUT with resp=2'b11 and the captured id, and increment wr_decerr_cnt (saturating at all-ones). On hit go to WR_FWD.
  - WR_FWD: assert m_aw_valid[p] and m_w_valid[p] together. Each drops independently after its own handshake, tracked by aw_done/w_done flags. When both are done (may be the same cycle), go to WR_RESP.
  - WR_RESP: m_b_ready[p]=1. On handshake, capture m_b_msg slice p and go to WR_BOUT.
  - WR_BOUT: s_b_valid=1, s_b_msg held stable until s_b_ready, then go to WR_IDLE.
- Read FSM states:
  - RD_IDLE: s_ar_ready=1. Capture AR and go to RD_FWD on hit, or to RD_ROUT on miss with {id, 2'b11, DATA_W'0} and rd_decerr_cnt incremented.
  - RD_FWD: m_ar_valid[p] until handshake, then RD_RESP.
  - RD_RESP: m_r_ready[p]=1; capture R, then RD_ROUT.
  - RD_ROUT: s_r_valid held until s_r_ready, then RD_IDLE.
- Port selection and ready rules:
  - Only the selected port's valid/ready bit is ever 1; all other m_*_valid and m_*_ready bits are 0.
  - m_b_valid and m_r_valid from unselected ports are ignored, not acked, and not counted.
- Minimum latencies, with zero-wait downstream and upstream:
  - Write hit: AW accepted cycle 0, W cycle 1, m_aw/m_w valid cycle 2, B captured cycle 3, s_b_valid cycle 4. Next AW accepted cycle 5 at the earliest.
  - Read hit: AR cycle 0, m_ar_valid cycle 1, R captured cycle 2, s_r_valid cycle 3.
  - Miss: s_b_valid 2 cycles after AW; s_r_valid 1 cycle after AR.
- Valid outputs never drop without a handshake. Msg outputs are stable while valid is 1.

Test Plan:
- Reset, then a write to 0x0001_0004 (port 1; defaults overridden to base 0x0000_0000 / 0x0001_0000) with data 0xDEADBEEF, strb 0xF, id 3 -> only m_aw_valid[1]/m_w_valid[1] assert; s_b_msg={3, 2'b00} at cycle 4.
- Read of unmapped 0x8000_0000 with id 5 -> no m_ar_valid; s_r_msg={5, 2'b11, 0} one cycle after AR; rd_decerr_cnt=1.
- Port 0 holds m_w_ready low for 5 cycles while m_aw_ready=1 -> m_aw_valid drops after 1 cycle, m_w_valid stays high and stable; B is accepted only after W completes.
- Concurrent write to port 0 and read from port 1, with s_b_ready and s_r_ready each held low for 3 cycles -> both complete, responses are correct, and s_b_msg/s_r_msg stay stable while stalled.
- Force CNT_W=2 and issue 5 write misses -> wr_decerr_cnt saturates at 3.
- Assert reset_bar=0 during WR_RESP -> all valids 0 immediately; after release, the first ready appears one cycle late and the new write completes normally.
